// File: rtl/debounce_bank.sv
// Multi-channel button debouncer with press/release pulses and typematic auto-repeat.
// Each channel: optional inversion, 2-FF synchroniser, debounce counter, repeat FSM.
module debounce_bank #(
  parameter int             N               = 4,
  parameter int             CTR_WIDTH       = 16,
  parameter logic [N-1:0]   ACTIVE_LOW_MASK = '0,
  parameter bit             REPEAT_EN       = 1'b1,
  parameter int             REPEAT_DELAY    = 2**22,
  parameter int             REPEAT_PERIOD   = 2**20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] noisy,
  output logic [N-1:0] clean,
  output logic [N-1:0] press_p,
  output logic [N-1:0] release_p,
  output logic [N-1:0] repeat_p
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  // state | meaning
  // IDLE  | button released, no repeat timing
  // HOLD  | accepted press, waiting REPEAT_DELAY for the first repeat
  // RPT   | repeating every REPEAT_PERIOD cycles
  typedef enum logic [1:0] {IDLE, HOLD, RPT} rpt_state_e;

  logic [N-1:0] s0, s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= noisy ^ ACTIVE_LOW_MASK;
      s1 <= s0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [CTR_WIDTH-1:0] cnt_q;
    logic                 clean_q, press_q, rel_q, rpt_q;
    logic                 accept, rise, fall;
    rpt_state_e           state_q, state_d;
    logic [RW-1:0]        rcnt_q, rcnt_d;
    logic                 fire;

    assign accept = (s1[i] != clean_q) && (&cnt_q);
    assign rise   = accept & s1[i];
    assign fall   = accept & ~s1[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        clean_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= rise;
        rel_q   <= fall;
        if (s1[i] == clean_q) begin
          cnt_q <= '0;
        end else if (accept) begin
          clean_q <= s1[i];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        rcnt_q  <= '0;
        rpt_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
        rpt_q   <= fire;
      end
    end

    // An accepted fall wins over a repeat due on the same edge.
    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      fire    = 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = HOLD;
            rcnt_d  = '0;
          end
        end
        HOLD: begin
          if (fall) begin
            state_d = IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == DLY_LAST) begin
            if (REPEAT_EN) begin
              fire    = 1'b1;
              state_d = RPT;
              rcnt_d  = '0;
            end
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        RPT: begin
          if (fall) begin
            state_d = IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == PER_LAST) begin
            fire   = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end

    assign clean[i]     = clean_q;
    assign press_p[i]   = press_q;
    assign release_p[i] = rel_q;
    assign repeat_p[i]  = rpt_q;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: N=2, CTR_WIDTH=2, delay 6, period 3, ch1 active-low.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] noisy;
  logic [1:0] clean, press_p, release_p, repeat_p;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .N              (2),
    .CTR_WIDTH      (2),
    .ACTIVE_LOW_MASK(2'b10),
    .REPEAT_EN      (1'b1),
    .REPEAT_DELAY   (6),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .noisy    (noisy),
    .clean    (clean),
    .press_p  (press_p),
    .release_p(release_p),
    .repeat_p (repeat_p)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got clean/press/rel/rpt=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] c, input logic [1:0] p,
                            input logic [1:0] r, input logic [1:0] rp);
    check(tag, {clean, press_p, release_p, repeat_p}, {c, p, r, rp});
  endtask

  // Raise ch0 raw at a negedge; accepted press becomes visible at the 6th negedge.
  task automatic press_ch0(input string tag);
    noisy[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      expect_out(tag, (k == 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00);
    end
  endtask

  // c=0 is the press cycle of ch0. Raw is dropped at cycle rel_set, so the
  // release shows at rel_set+6; repeats at 6, 9, 12, ... strictly before that.
  task automatic hold_ch0(input string tag, input int rel_set, input int last);
    int rel_vis;
    rel_vis = rel_set + 6;
    for (int c = 1; c <= last; c++) begin
      logic rpt;
      @(negedge clk);
      rpt = (c < rel_vis) && (c >= 6) && (((c - 6) % 3) == 0);
      expect_out(tag, (c < rel_vis) ? 2'b01 : 2'b00, 2'b00,
                 (c == rel_vis) ? 2'b01 : 2'b00, {1'b0, rpt});
      if (c == rel_set) noisy[0] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    noisy = 2'b10;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    expect_out("reset_hold", 2'b00, 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      expect_out("post_reset_idle", 2'b00, 2'b00, 2'b00, 2'b00);
    end

    press_ch0("latency_press");
    hold_ch0("autorepeat", 13, 24);

    noisy[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      expect_out("glitch_3cyc", 2'b00, 2'b00, 2'b00, 2'b00);
      if (k == 3) noisy[0] = 1'b0;
    end

    noisy[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      expect_out("pulse_4cyc", (k >= 6 && k <= 9) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00,
                 (k == 10) ? 2'b01 : 2'b00, 2'b00);
      if (k == 4) noisy[0] = 1'b0;
    end

    press_ch0("collision_press");
    hold_ch0("rpt_release_collision", 9, 20);

    noisy = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      expect_out("simul_pre_press", (k == 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00,
                 2'b00, 2'b00);
    end
    noisy = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      expect_out("simul_events", (k < 6) ? 2'b01 : 2'b10, (k == 6) ? 2'b10 : 2'b00,
                 (k == 6) ? 2'b01 : 2'b00, 2'b00);
    end
    repeat (2) begin
      @(negedge clk);
      expect_out("ch1_hold", 2'b10, 2'b00, 2'b00, 2'b00);
    end

    rst_n = 1'b0;
    #1;
    expect_out("async_reset_mid_hold", 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (2) begin
      @(negedge clk);
      expect_out("reset_held", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      expect_out("held_at_reset_release", (k >= 6) ? 2'b10 : 2'b00,
                 (k == 6) ? 2'b10 : 2'b00, 2'b00, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel debouncer with edge events and typematic auto-repeat. It turns a vector of raw, noisy push-button or switch inputs into stable levels, one-cycle press/release pulses, and periodic repeat pulses while a button is held. It sits between the board I/O pins and the front-panel control logic (step, run, address/data entry), and replaces per-button single-channel debounce instances.

## Interface
Parameters:
- `N`, 4: number of channels (≥1).
- `CTR_WIDTH`, 16: debounce counter width; acceptance time is 2^CTR_WIDTH cycles.
- `ACTIVE_LOW_MASK`, '0 (N bits): bit i=1 inverts raw input i before synchronisation, so all outputs are active-high.
- `REPEAT_EN`, 1: 0 disables auto-repeat; `repeat_p` stays 0.
- `REPEAT_DELAY`, 2**22: cycles from press pulse to first repeat pulse (≥1).
- `REPEAT_PERIOD`, 2**20: cycles between subsequent repeat pulses (≥1).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `noisy` in N: raw asynchronous button inputs.
- `clean` out N: debounced level per channel.
- `press_p` out N: one-cycle pulse on accepted 0→1 of `clean`.
- `release_p` out N: one-cycle pulse on accepted 1→0 of `clean`.
- `repeat_p` out N: one-cycle auto-repeat pulse while held.

## Operation
- Per channel: apply inversion (`ACTIVE_LOW_MASK`), then a 2-FF synchroniser (`s0`, `s1`), then a debounce counter, then the repeat FSM. Channels are fully independent.
- Debounce counter (CTR_WIDTH bits):
  - If `s1 == clean`: counter ← 0.
  - Otherwise counter ← counter+1.
  - If the counter is all-ones and `s1 != clean` on that edge: `clean` ← `s1` and counter ← 0 (the counter wraps naturally).
  - Any single cycle of agreement restarts the count.
- Pulses are registered on the same edge that updates `clean`:
  - `press_p` is high exactly in the first cycle `clean`=1.
  - `release_p` is high exactly in the first cycle `clean`=0.
- Repeat FSM per channel, states IDLE, HOLD, RPT; repeat counter width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
  - IDLE: on accepted rise → HOLD, rcnt ← 0.
  - HOLD: rcnt increments. When rcnt == REPEAT_DELAY-1 and REPEAT_EN: assert `repeat_p`, → RPT, rcnt ← 0. With REPEAT_EN=0 it stays in HOLD with rcnt saturated.
  - RPT: rcnt increments. When rcnt == REPEAT_PERIOD-1: assert `repeat_p`, rcnt ← 0.
  - HOLD/RPT: on accepted fall → IDLE, rcnt ← 0, assert `release_p`. Release has priority: no `repeat_p` on that edge.
- Reset (`rst_n`=0, asynchronous): `s0`, `s1`, counters and `clean` ← 0; `press_p`, `release_p`, `repeat_p` ← 0; FSM ← IDLE.
  - For an active-low channel held idle (raw=1), the inverted value is 0, so there are no events after reset.
  - A button already held at reset release produces a press only after full debounce.
  - Reset mid-count discards all progress.

## Timing
- Latency: raw change settles before edge e0 and stays stable. `s1` reflects it after e0+1. `clean` and `press_p`/`release_p` are visible after edge e0+1+2^CTR_WIDTH.
- Glitches shorter than 2^CTR_WIDTH cycles (measured at `s1`) never change `clean`.
- Press pulse visible in cycle t: repeats occur in cycles t+REPEAT_DELAY, then t+REPEAT_DELAY+k·REPEAT_PERIOD for k≥1, until release.
- At most one of `press_p`/`release_p` per channel per cycle. `repeat_p` never coincides with `press_p` or `release_p` on the same channel.
- Multiple channels may pulse in the same cycle.
- All outputs are registered; no combinational path from `noisy`.

## Test plan
Bench parameters: N=2, CTR_WIDTH=2, REPEAT_DELAY=6, REPEAT_PERIOD=3, ACTIVE_LOW_MASK=2'b10.
- **Reset:** hold `rst_n`=0 with `noisy`=2'b10, release it, run 20 cycles. Expect `clean`=0 and no pulses.
- **Debounce latency:** ch0 0→1 before edge e0, held. Expect `clean[0]`=1 and a single `press_p[0]` after edge e0+5, nothing earlier.
- **Glitch rejection:** ch0 high for 3 cycles, then low. Expect `clean[0]` to stay 0 and no pulses. Then hold it high for 4 cycles at `s1`. Expect a press.
- **Auto-repeat:** hold ch0. With press at cycle t, expect `repeat_p[0]` at t+6, t+9, t+12. Release it. Expect `release_p[0]` only, after debounce, with no further repeats.
- **Release vs repeat collision:** time the accepted fall to the edge where rcnt==2 in RPT. Expect `release_p[0]`=1 and `repeat_p[0]`=0 in that cycle.
- **Active-low and simultaneous events:** drive ch1 raw 1→0 while ch0 is released on the same cycle. Expect `press_p[1]` and `release_p[0]` in the same cycle. Assert `rst_n` mid-HOLD and expect all outputs 0 immediately.
